pe_seq_driver: RTL and testbench

//  Job sequencer that drives the control side of one spad-based PE. Buffers weights/acts from

---
 rtl/pe_seq_driver_if.sv | 74 +++++++
 rtl/pe_seq_driver.sv | 190 +++++++++++++++++++
 tb/tb_pe_seq_driver.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_seq_driver_if.sv
// Control/data bundle between the PE job sequencer and its surroundings.
// Groups the job control, the three upstream streams (weights, acts,
// neighbour psums), the PE control/data side and the result stream.
//   slave  : modport used by pe_seq_driver
//   master : modport used by whatever drives/observes the sequencer
interface pe_seq_driver_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PSUM_W = 2 * DATA_W + 4
);
    localparam int unsigned CFG_W = 8;

    // job control
    logic              job_start;
    logic [CFG_W-1:0]  cfg_acount;
    logic [CFG_W-1:0]  cfg_wcount;
    logic              cfg_keep_w;
    logic              job_busy;
    logic              job_done;
    logic              job_err;

    // upstream streams
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] a_data;
    logic              pin_valid;
    logic              pin_ready;
    logic [PSUM_W-1:0] pin_data;

    // PE side
    logic [DATA_W-1:0] pe_weights;
    logic [DATA_W-1:0] pe_acts;
    logic [PSUM_W-1:0] pe_psum;
    logic              pe_loadw;
    logic              pe_loada;
    logic              pe_start;
    logic              pe_sums;
    logic [CFG_W-1:0]  pe_acount;
    logic [CFG_W-1:0]  pe_wcount;
    logic [PSUM_W-1:0] pe_res;
    logic              pe_res_valid;
    logic              pe_done;

    // result stream
    logic              out_valid;
    logic              out_ready;
    logic [PSUM_W-1:0] out_psum;

    modport slave (
        input  job_start, cfg_acount, cfg_wcount, cfg_keep_w,
        output job_busy, job_done, job_err,
        input  w_valid, w_data, a_valid, a_data, pin_valid, pin_data,
        output w_ready, a_ready, pin_ready,
        output pe_weights, pe_acts, pe_psum, pe_loadw, pe_loada, pe_start, pe_sums,
        output pe_acount, pe_wcount,
        input  pe_res, pe_res_valid, pe_done,
        output out_valid, out_psum,
        input  out_ready
    );

    modport master (
        output job_start, cfg_acount, cfg_wcount, cfg_keep_w,
        input  job_busy, job_done, job_err,
        output w_valid, w_data, a_valid, a_data, pin_valid, pin_data,
        input  w_ready, a_ready, pin_ready,
        input  pe_weights, pe_acts, pe_psum, pe_loadw, pe_loada, pe_start, pe_sums,
        input  pe_acount, pe_wcount,
        output pe_res, pe_res_valid, pe_done,
        input  out_valid, out_psum,
        output out_ready
    );
endinterface

// File: rtl/pe_seq_driver.sv
// Job sequencer for one spad-based PE.
// Buffers a job's weights/acts from valid/ready streams, bursts them into the
// PE contiguously, starts the 1D conv, feeds neighbour psums during the sums
// phase and queues the PE's psum results in a small output FIFO.
// Ports:
//   clk  - clock
//   nrst - asynchronous active-low reset (aborts a running job, no done pulse)
//   bus  - pe_seq_driver_if.slave: job control, w/a/pin streams, PE side,
//          result stream. *_ready and out_* are combinational, the rest registered.
module pe_seq_driver #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PSUM_W    = 2 * DATA_W + 4,
    parameter int unsigned RF_DEPTH  = 16,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic           clk,
    input  logic           nrst,
    pe_seq_driver_if.slave bus
);
    localparam int unsigned CFG_W = 8;
    localparam int unsigned IDX_W = $clog2(RF_DEPTH);
    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_LOAD, S_GAP, S_START, S_COMPUTE, S_SUMS, S_DRAIN, S_DONE
    } state_t;

    state_t            state;
    logic [CFG_W-1:0]  cfg_a, cfg_w, oc;
    logic              keep_w;
    logic [CFG_W-1:0]  wcnt, acnt, lidx, issued, rcvd;
    logic [DATA_W-1:0] wbuf [RF_DEPTH];
    logic [DATA_W-1:0] abuf [RF_DEPTH];
    logic [PSUM_W-1:0] fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  rptr, wptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic              cfg_ok, w_beat, a_beat, issue, push, pop;
    logic [CFG_W:0]    occ;

    // Config legality: 1 <= W <= RF_DEPTH and W <= A <= RF_DEPTH.
    assign cfg_ok = (bus.cfg_wcount != '0) &&
                    (bus.cfg_wcount <= CFG_W'(RF_DEPTH)) &&
                    (bus.cfg_wcount <= bus.cfg_acount) &&
                    (bus.cfg_acount <= CFG_W'(RF_DEPTH));

    assign bus.w_ready = (state == S_FILL) && !keep_w && (wcnt < cfg_w);
    assign bus.a_ready = (state == S_FILL) && (acnt < cfg_a);
    assign w_beat      = bus.w_valid && bus.w_ready;
    assign a_beat      = bus.a_valid && bus.a_ready;

    // FIFO slots already promised: stored entries plus psums issued but not yet captured.
    assign occ   = (CFG_W+1)'(fifo_cnt) + (CFG_W+1)'(issued - rcvd);
    assign issue = (state == S_SUMS) && (issued < oc) && bus.pin_valid &&
                   (occ < (CFG_W+1)'(OUT_DEPTH));
    assign bus.pin_ready = issue;

    assign push = bus.pe_res_valid && ((state == S_SUMS) || (state == S_DRAIN));
    assign pop  = bus.out_valid && bus.out_ready;

    assign bus.out_valid = (fifo_cnt != '0);
    assign bus.out_psum  = fifo_mem[rptr];
    assign bus.pe_acount = cfg_a;
    assign bus.pe_wcount = cfg_w;

    // Staging buffers and FIFO storage; no reset needed on data.
    always_ff @(posedge clk) begin
        if (w_beat) wbuf[wcnt[IDX_W-1:0]] <= bus.w_data;
        if (a_beat) abuf[acnt[IDX_W-1:0]] <= bus.a_data;
        if (push)   fifo_mem[wptr]        <= bus.pe_res;
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rptr     <= '0;
            wptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wptr <= (wptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
            if (pop)  rptr <= (rptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Job FSM with registered PE controls; controls lag the state by one cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= S_IDLE;
            cfg_a          <= '0;
            cfg_w          <= '0;
            oc             <= '0;
            keep_w         <= 1'b0;
            wcnt           <= '0;
            acnt           <= '0;
            lidx           <= '0;
            issued         <= '0;
            rcvd           <= '0;
            bus.job_busy   <= 1'b0;
            bus.job_done   <= 1'b0;
            bus.job_err    <= 1'b0;
            bus.pe_weights <= '0;
            bus.pe_acts    <= '0;
            bus.pe_psum    <= '0;
            bus.pe_loadw   <= 1'b0;
            bus.pe_loada   <= 1'b0;
            bus.pe_start   <= 1'b0;
            bus.pe_sums    <= 1'b0;
        end else begin
            bus.job_done <= 1'b0;
            bus.job_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.job_start) begin
                        if (cfg_ok) begin
                            cfg_a        <= bus.cfg_acount;
                            cfg_w        <= bus.cfg_wcount;
                            keep_w       <= bus.cfg_keep_w;
                            oc           <= bus.cfg_acount - bus.cfg_wcount + CFG_W'(1);
                            wcnt         <= '0;
                            acnt         <= '0;
                            issued       <= '0;
                            rcvd         <= '0;
                            bus.job_busy <= 1'b1;
                            state        <= S_FILL;
                        end else begin
                            bus.job_err  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (w_beat) wcnt <= wcnt + CFG_W'(1);
                    if (a_beat) acnt <= acnt + CFG_W'(1);
                    if ((keep_w || (wcnt == cfg_w)) && (acnt == cfg_a)) begin
                        lidx  <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Acts on every cycle; weights only for the first W when not reused.
                    bus.pe_loada   <= 1'b1;
                    bus.pe_acts    <= abuf[lidx[IDX_W-1:0]];
                    bus.pe_loadw   <= !keep_w && (lidx < cfg_w);
                    bus.pe_weights <= (!keep_w && (lidx < cfg_w)) ? wbuf[lidx[IDX_W-1:0]] : '0;
                    lidx           <= lidx + CFG_W'(1);
                    if (lidx == cfg_a - CFG_W'(1)) state <= S_GAP;
                end
                S_GAP: begin
                    // Idle cycle lets the PE spad addresses return to 0.
                    bus.pe_loada   <= 1'b0;
                    bus.pe_loadw   <= 1'b0;
                    bus.pe_acts    <= '0;
                    bus.pe_weights <= '0;
                    state          <= S_START;
                end
                S_START: begin
                    bus.pe_start <= 1'b1;
                    state        <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    bus.pe_start <= 1'b0;
                    if (bus.pe_done) state <= S_SUMS;
                end
                S_SUMS: begin
                    bus.pe_sums <= issue;
                    bus.pe_psum <= issue ? bus.pin_data : '0;
                    if (issue) issued <= issued + CFG_W'(1);
                    if (issued == oc) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    bus.pe_sums <= 1'b0;
                    bus.pe_psum <= '0;
                    if (rcvd == oc) begin
                        bus.job_done <= 1'b1;
                        bus.job_busy <= 1'b0;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (push) rcvd <= rcvd + CFG_W'(1);
        end
    end
endmodule

// File: tb/tb_pe_seq_driver.sv
// Directed bench for pe_seq_driver with a behavioural PE model.
module tb_pe_seq_driver;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PSUM_W = 20;

    logic clk;
    logic nrst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pe_seq_driver_if #(.DATA_W(DATA_W), .PSUM_W(PSUM_W)) bus ();

    pe_seq_driver #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .RF_DEPTH(16), .OUT_DEPTH(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    // Behavioural PE: spads fill on load strobes, conv result per sums cycle, valid 1 cycle later.
    logic [DATA_W-1:0] pw [16];
    logic [DATA_W-1:0] pa [16];
    logic [3:0]        wp, ap;
    int                k, dly;

    function automatic logic [PSUM_W-1:0] conv(input int kk);
        int acc = 0;
        for (int j = 0; j < int'(bus.pe_wcount); j++)
            acc += int'(pw[4'(j)]) * int'(pa[4'(kk + j)]);
        return PSUM_W'(acc);
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wp <= '0; ap <= '0; k <= 0; dly <= 0;
            bus.pe_done <= 1'b0; bus.pe_res_valid <= 1'b0; bus.pe_res <= '0;
        end else begin
            bus.pe_done      <= 1'b0;
            bus.pe_res_valid <= 1'b0;
            if (bus.pe_loadw) begin pw[wp] <= bus.pe_weights; wp <= wp + 4'd1; end
            else wp <= '0;
            if (bus.pe_loada) begin pa[ap] <= bus.pe_acts; ap <= ap + 4'd1; end
            else ap <= '0;
            if (bus.pe_start) begin dly <= 3; k <= 0; end
            else if (dly != 0) begin
                dly <= dly - 1;
                if (dly == 1) bus.pe_done <= 1'b1;
            end
            if (bus.pe_sums) begin
                bus.pe_res       <= conv(k) + bus.pe_psum;
                bus.pe_res_valid <= 1'b1;
                k                <= k + 1;
            end
        end
    end

    // Activity monitor, cleared per job.
    logic mon_clr;
    int   cyc = 0, n_lw, n_la, runs_w, runs_a, n_st, n_sums, n_done, first_s, last_s;
    bit   gap_ok, wr_seen, lw_d1, la_d1, la_d2, s_seen;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        lw_d1 <= bus.pe_loadw;
        la_d1 <= bus.pe_loada;
        la_d2 <= la_d1;
        if (mon_clr) begin
            n_lw <= 0; n_la <= 0; runs_w <= 0; runs_a <= 0; n_st <= 0; n_sums <= 0;
            n_done <= 0; first_s <= 0; last_s <= 0; gap_ok <= 0; wr_seen <= 0; s_seen <= 0;
        end else begin
            if (bus.pe_loadw) n_lw <= n_lw + 1;
            if (bus.pe_loada) n_la <= n_la + 1;
            if (bus.pe_loadw && !lw_d1) runs_w <= runs_w + 1;
            if (bus.pe_loada && !la_d1) runs_a <= runs_a + 1;
            if (bus.pe_start) begin n_st <= n_st + 1; gap_ok <= !la_d1 && la_d2; end
            if (bus.pe_sums) begin
                n_sums <= n_sums + 1;
                if (!s_seen) first_s <= cyc;
                s_seen <= 1'b1;
                last_s <= cyc;
            end
            if (bus.job_done) n_done <= n_done + 1;
            if (bus.w_ready) wr_seen <= 1'b1;
        end
    end

    logic [DATA_W-1:0] wv [16];
    logic [DATA_W-1:0] av [16];
    logic [PSUM_W-1:0] pv [16];
    logic [PSUM_W-1:0] ev [16];

    task automatic drive_w(input int n);
        int i = 0;
        int t = 0;
        while (i < n && t < 300) begin
            @(negedge clk); bus.w_valid = 1'b1; bus.w_data = wv[i]; #1;
            if (bus.w_ready) i++;
            t++;
        end
        chk("w_beats", i, n);
        @(posedge clk); #1; bus.w_valid = 1'b0;
    endtask

    task automatic drive_a(input int n, input bit tog);
        int i = 0;
        int t = 0;
        bit ph = 1'b0;
        while (i < n && t < 300) begin
            @(negedge clk);
            if (tog && ph) bus.a_valid = 1'b0;
            else begin
                bus.a_valid = 1'b1; bus.a_data = av[i]; #1;
                if (bus.a_ready) i++;
            end
            ph = ~ph;
            t++;
        end
        chk("a_beats", i, n);
        @(posedge clk); #1; bus.a_valid = 1'b0;
    endtask

    task automatic drive_pin(input int n, input bit gap);
        int i = 0;
        int t = 0;
        int gl = 0;
        while (i < n && t < 400) begin
            @(negedge clk);
            if (gl > 0) begin bus.pin_valid = 1'b0; gl--; end
            else begin
                bus.pin_valid = 1'b1; bus.pin_data = pv[i]; #1;
                if (bus.pin_ready) begin
                    i++;
                    if (gap && i == 1) gl = 3;
                end
            end
            t++;
        end
        chk("pin_beats", i, n);
        @(posedge clk); #1; bus.pin_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit hold);
        int i = 0;
        int t = 0;
        if (hold) begin
            bus.out_ready = 1'b0;
            repeat (40) @(negedge clk);
            chk("hold_issued", n_sums, 4);
            chk("hold_busy", bus.job_busy, 1);
        end
        while (i < n && t < 400) begin
            @(negedge clk); bus.out_ready = 1'b1; #1;
            if (bus.out_valid) begin chk($sformatf("psum%0d", i), bus.out_psum, ev[i]); i++; end
            t++;
        end
        chk("out_count", i, n);
        @(posedge clk); #1; bus.out_ready = 1'b0;
    endtask

    task automatic run_job(input int wn, input int an, input bit keep, input bit atog,
                           input bit pgap, input bit hold);
        int oc = an - wn + 1;
        @(negedge clk);
        mon_clr = 1'b1;
        bus.cfg_wcount = 8'(wn); bus.cfg_acount = 8'(an); bus.cfg_keep_w = keep;
        bus.job_start = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0; bus.job_start = 1'b0;
        chk("busy_on", bus.job_busy, 1);
        chk("acount", bus.pe_acount, an);
        chk("wcount", bus.pe_wcount, wn);
        fork
            begin if (!keep) drive_w(wn); end
            drive_a(an, atog);
            drive_pin(oc, pgap);
            collect(oc, hold);
        join
        for (int t = 0; t < 30 && n_done == 0; t++) @(negedge clk);
        @(negedge clk);
        chk("done_cnt", n_done, 1);
        chk("busy_off", bus.job_busy, 0);
        chk("loada_cyc", n_la, an);
        chk("loada_runs", runs_a, 1);
        chk("loadw_cyc", n_lw, keep ? 0 : wn);
        chk("loadw_runs", runs_w, keep ? 0 : 1);
        chk("wready_seen", wr_seen, keep ? 0 : 1);
        chk("start_cnt", n_st, 1);
        chk("gap_one", gap_ok, 1);
        chk("sums_cnt", n_sums, oc);
        if (pgap) chk("sums_span", last_s - first_s + 1, oc + 3);
    endtask

    task automatic err_job(input int wn, input int an);
        @(negedge clk);
        bus.cfg_wcount = 8'(wn); bus.cfg_acount = 8'(an); bus.cfg_keep_w = 1'b0;
        bus.job_start = 1'b1;
        @(negedge clk);
        bus.job_start = 1'b0;
        chk("err_pulse", bus.job_err, 1);
        chk("err_busy", bus.job_busy, 0);
        @(negedge clk);
        chk("err_clear", bus.job_err, 0);
        chk("err_aready", bus.a_ready, 0);
    endtask

    task automatic set_job1();
        for (int i = 0; i < 3; i++) wv[i] = 8'(i + 1);
        for (int i = 0; i < 5; i++) av[i] = 8'(i + 1);
        for (int i = 0; i < 3; i++) pv[i] = '0;
        ev[0] = 20'd14; ev[1] = 20'd20; ev[2] = 20'd26;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; mon_clr = 1'b0;
        bus.job_start = 1'b0; bus.cfg_acount = '0; bus.cfg_wcount = '0; bus.cfg_keep_w = 1'b0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.a_valid = 1'b0; bus.a_data = '0;
        bus.pin_valid = 1'b0; bus.pin_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.job_busy, 0);
        chk("rst_done", bus.job_done, 0);
        chk("rst_err", bus.job_err, 0);
        chk("rst_outv", bus.out_valid, 0);
        chk("rst_wready", bus.w_ready, 0);
        chk("rst_loada", bus.pe_loada, 0);
        chk("rst_sums", bus.pe_sums, 0);
        chk("rst_acount", bus.pe_acount, 0);
        nrst = 1'b1;

        // Basic job, then the same job with a gappy activation stream.
        set_job1();
        run_job(3, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(3, 5, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reuse resident weights 1,2,3 with new acts and neighbour psums.
        av[0] = 8'd2; av[1] = 8'd0; av[2] = 8'd1; av[3] = 8'd3;
        pv[0] = 20'd100; pv[1] = 20'd200;
        ev[0] = 20'd105; ev[1] = 20'd211;
        run_job(3, 4, 1'b1, 1'b0, 1'b0, 1'b0);

        // OC=6 against a 4-deep FIFO with the result stream held off.
        wv[0] = 8'd2;
        for (int i = 0; i < 6; i++) begin
            av[i] = 8'(i + 1); pv[i] = '0; ev[i] = 20'(2 * (i + 1));
        end
        run_job(1, 6, 1'b0, 1'b0, 1'b0, 1'b1);

        // Neighbour psum stream pauses 3 cycles after the first beat.
        wv[0] = 8'd1; wv[1] = 8'd1;
        for (int i = 0; i < 5; i++) av[i] = 8'(i + 1);
        pv[0] = 20'd10; pv[1] = 20'd20; pv[2] = 20'd30; pv[3] = 20'd40;
        ev[0] = 20'd13; ev[1] = 20'd25; ev[2] = 20'd37; ev[3] = 20'd49;
        run_job(2, 5, 1'b0, 1'b0, 1'b1, 1'b0);

        // Illegal configurations.
        err_job(0, 5);
        err_job(3, 17);
        err_job(4, 3);

        // Abort a job in SUMS with results already queued.
        @(negedge clk);
        bus.cfg_wcount = 8'd1; bus.cfg_acount = 8'd6; bus.cfg_keep_w = 1'b0;
        bus.job_start = 1'b1;
        @(negedge clk);
        bus.job_start = 1'b0;
        bus.pin_valid = 1'b1; bus.pin_data = '0; bus.out_ready = 1'b0;
        fork
            drive_w(1);
            drive_a(6, 1'b0);
        join
        bus.pin_valid = 1'b1;
        for (int t = 0; t < 100 && !bus.out_valid; t++) @(negedge clk);
        chk("pre_rst_outv", bus.out_valid, 1);
        @(negedge clk);
        nrst = 1'b0; #1;
        chk("abort_sums", bus.pe_sums, 0);
        chk("abort_busy", bus.job_busy, 0);
        chk("abort_outv", bus.out_valid, 0);
        chk("abort_pinrdy", bus.pin_ready, 0);
        bus.pin_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;

        set_job1();
        run_job(3, 5, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
